// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants, state encoding and packing helper for the
// floating-point unit pipeline stages.
//   EXP_BIAS / EXP_MAX : single-precision exponent bias and saturating value
//   MANT_W / HIDDEN_BIT: raw ALU mantissa width and hidden-one position
//   *_POS / *_MSB / *_LSB : field positions inside a packed single word
//   fpu_state_t        : controller state encoding shared with the ALU
//   pack_single()      : assembles {sign, exp, frac} into a 32-bit word
package fpu_pkg;

  localparam int EXP_BIAS   = 127;
  localparam int EXP_MAX    = 255;
  localparam int MANT_W     = 28;
  localparam int HIDDEN_BIT = 26;

  localparam int SIGN_POS = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    ROUND,
    PACK,
    DONE
  } fpu_state_t;

  // Builds a packed single from its three fields.
  function automatic logic [31:0] pack_single(
    input logic                       sign,
    input logic [EXP_MSB-EXP_LSB:0]   exp,
    input logic [FRAC_MSB:0]          frac
  );
    logic [31:0] word;
    word                   = '0;
    word[SIGN_POS]         = sign;
    word[EXP_MSB:EXP_LSB]  = exp;
    word[FRAC_MSB:0]       = frac;
    return word;
  endfunction

endpackage

// File: rtl/fpu_round_rne.sv
// fpu_round_rne: combinational round-to-nearest-even on a raw mantissa
// whose three least significant bits are guard, round and sticky.
//   mant      in  MANT_W : mantissa to round (bit 3 is the kept LSB)
//   rounded   out MANT_W : rounded mantissa, guard bits cleared
//   carry_out out 1      : rounding rippled into the top (carry) bit
module fpu_round_rne
  import fpu_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  output logic [MANT_W-1:0] rounded,
  output logic              carry_out
);

  logic              inc;
  logic [MANT_W-4:0] upper;

  // Round up when above half, or exactly half with an odd kept LSB.
  always_comb begin
    inc       = mant[2] & (mant[3] | mant[1] | mant[0]);
    upper     = mant[MANT_W-1:3] + {{(MANT_W-4){1'b0}}, inc};
    rounded   = {upper, 3'b000};
    carry_out = upper[MANT_W-4];
  end

endmodule

// File: rtl/fpu_norm_round.sv
// fpu_norm_round: normalizes the ALU's raw mantissa one step per cycle,
// rounds to nearest even, range-checks the exponent and packs an IEEE-754
// single. Uses the same start/finish handshake as the mantissa ALU.
//   clk, reset       : clock and asynchronous active-high reset
//   start            : request, accepted only in IDLE or DONE
//   sign_in, exp_in  : sign and biased exponent (leading one at bit 26)
//   mant_in          : raw mantissa {carry, hidden, frac[22:0], G, R, S}
//   result           : packed single, valid while finish is high
//   finish           : result valid, held until the next accepted start
//   overflow         : result saturated to infinity
//   underflow        : result flushed to zero
module fpu_norm_round
  import fpu_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  output logic [31:0]       result,
  output logic              finish,
  output logic              overflow,
  underflow
);

  // Two spare bits so neither the +2 of carries nor the -26 of left
  // shifts can wrap, whatever the input exponent.
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_TOP  = EW'(EXP_MAX);

  fpu_state_t             state, state_next;
  logic                   sign_q, sign_next;
  logic [MANT_W-1:0]      mant_q, mant_next;
  logic signed [EW-1:0]   exp_q, exp_next;
  logic [31:0]            result_next;
  logic                   finish_next, overflow_next, underflow_next;
  logic [MANT_W-1:0]      mant_rounded;
  logic                   round_carry;

  fpu_round_rne u_round (
    .mant      (mant_q),
    .rounded   (mant_rounded),
    .carry_out (round_carry)
  );

  // Next-state and datapath decisions. Outputs are only computed here and
  // registered below, so nothing reaches the ports combinationally.
  always_comb begin
    state_next     = state;
    sign_next      = sign_q;
    mant_next      = mant_q;
    exp_next       = exp_q;
    result_next    = result;
    finish_next    = finish;
    overflow_next  = overflow;
    underflow_next = underflow;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          sign_next      = sign_in;
          mant_next      = mant_in;
          exp_next       = $signed({{2{exp_in[EXP_W-1]}}, exp_in});
          result_next    = '0;
          finish_next    = 1'b0;
          overflow_next  = 1'b0;
          underflow_next = 1'b0;
          state_next     = NORM;
        end
      end

      NORM: begin
        if (mant_q == '0) begin
          state_next = ROUND;
        end else if (mant_q[MANT_W-1]) begin
          // Fold the bit shifted out into sticky so rounding stays exact.
          mant_next  = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
          exp_next   = exp_q + EXP_ONE;
          state_next = ROUND;
        end else if (mant_q[HIDDEN_BIT]) begin
          state_next = ROUND;
        end else begin
          mant_next = {mant_q[MANT_W-2:0], 1'b0};
          exp_next  = exp_q - EXP_ONE;
        end
      end

      ROUND: begin
        if (round_carry) begin
          mant_next = {1'b0, mant_rounded[MANT_W-1:1]};
          exp_next  = exp_q + EXP_ONE;
        end else begin
          mant_next = mant_rounded;
        end
        state_next = PACK;
      end

      PACK: begin
        finish_next = 1'b1;
        state_next  = DONE;
        if (mant_q == '0) begin
          result_next = pack_single(sign_q, 8'h00, 23'h0);
        end else if (exp_q <= EXP_ZERO) begin
          result_next    = pack_single(sign_q, 8'h00, 23'h0);
          underflow_next = 1'b1;
        end else if (exp_q >= EXP_TOP) begin
          result_next   = pack_single(sign_q, 8'hFF, 23'h0);
          overflow_next = 1'b1;
        end else begin
          result_next = pack_single(sign_q, exp_q[7:0],
                                    mant_q[HIDDEN_BIT-1:3]);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State, datapath and output registers; reset abandons any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      mant_q    <= '0;
      exp_q     <= '0;
      result    <= '0;
      finish    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_next;
      sign_q    <= sign_next;
      mant_q    <= mant_next;
      exp_q     <= exp_next;
      result    <= result_next;
      finish    <= finish_next;
      overflow  <= overflow_next;
      underflow <= underflow_next;
    end
  end

endmodule

// File: tb/tb_fpu_norm_round.sv
// tb_fpu_norm_round: directed and randomized checks of fpu_norm_round
// against a value-level round-to-nearest-even reference model.
module tb_fpu_norm_round;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sign_in;
  logic [9:0]  exp_in;
  logic [27:0] mant_in;
  logic [31:0] result;
  logic        finish;
  logic        overflow;
  logic        underflow;

  int check_count = 0;
  int error_count = 0;

  fpu_norm_round #(.EXP_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .result    (result),
    .finish    (finish),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Reference: treat the mantissa as an integer scaled by 2^(exp-127-26),
  // locate its leading one, round the value to 24 significant bits with
  // ties to even, then classify the resulting exponent.
  function automatic void ref_model(input logic sgn, input logic [9:0] exp_raw,
                                    input logic [27:0] mant,
                                    output logic [31:0] res, output logic ovf,
                                    output logic unf, output int lat);
    int     lead;
    int     e;
    int     s;
    longint q;
    longint rem;
    longint half;
    ovf = 1'b0;
    unf = 1'b0;
    lat = 3;
    res = {sgn, 31'b0};
    if (mant == 28'd0) return;
    lead = 0;
    for (int b = 0; b < 28; b++) if (mant[b]) lead = b;
    if (lead < 26) lat = 3 + (26 - lead);
    e = int'($signed(exp_raw)) + (lead - 26);
    s = lead - 23;
    if (s > 0) begin
      q    = longint'(mant) >> s;
      rem  = longint'(mant) & ((longint'(1) << s) - 1);
      half = longint'(1) << (s - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = longint'(mant) << (-s);
    end
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e <= 0) begin
      unf = 1'b1;
    end else if (e >= 255) begin
      ovf = 1'b1;
      res = {sgn, 8'hFF, 23'h0};
    end else begin
      res = {sgn, e[7:0], q[22:0]};
    end
  endfunction

  // Runs one operation: start on an edge, optionally pulse a stray start
  // before edge glitch_at, then check latency, result, flags and hold.
  task automatic applyStimulus(input string tag, input logic sgn,
                               input logic [9:0] e, input logic [27:0] m,
                               input int glitch_at);
    logic [31:0] exp_res;
    logic        exp_ovf;
    logic        exp_unf;
    int          exp_lat;
    int          lat;
    bit          done;
    ref_model(sgn, e, m, exp_res, exp_ovf, exp_unf, exp_lat);
    @(negedge clk);
    start   = 1'b1;
    sign_in = sgn;
    exp_in  = e;
    mant_in = m;
    @(posedge clk);
    #1;
    start   = 1'b0;
    sign_in = 1'($urandom);
    exp_in  = 10'($urandom);
    mant_in = 28'($urandom);
    checkOutput({tag, "_busy"}, {31'b0, finish}, 32'd0);
    lat  = 0;
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (c == glitch_at) begin
        @(negedge clk);
        start   = 1'b1;
        mant_in = 28'h8000000;
        exp_in  = 10'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (finish) begin
        done = 1'b1;
        lat  = c;
      end
    end
    if (!done) begin
      checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, "_result"}, result, exp_res);
      checkOutput({tag, "_overflow"}, {31'b0, overflow}, {31'b0, exp_ovf});
      checkOutput({tag, "_underflow"}, {31'b0, underflow}, {31'b0, exp_unf});
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold"}, {finish, result[30:0]}, {1'b1, exp_res[30:0]});
    end
  endtask

  initial begin
    int rises;
    int w;
    logic [27:0] m;
    logic [9:0]  e;

    reset   = 1'b1;
    start   = 1'b0;
    sign_in = 1'b0;
    exp_in  = '0;
    mant_in = '0;
    #1;
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_flags", {29'b0, finish, overflow, underflow}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus("one_plus_one", 1'b0, 10'd127, 28'h8000000, 0);
    applyStimulus("left_shift", 1'b0, 10'd130, 28'h0400000, 0);
    applyStimulus("tie_even_kept", 1'b0, 10'd127, 28'h4000004, 0);
    applyStimulus("tie_round_up", 1'b0, 10'd127, 28'h400000C, 0);
    applyStimulus("round_carry", 1'b0, 10'd127, 28'h7FFFFFC, 0);
    applyStimulus("underflow", 1'b0, 10'd1, 28'h2000000, 0);
    applyStimulus("zero", 1'b1, 10'd77, 28'h0000000, 0);
    applyStimulus("overflow", 1'b1, 10'd254, 28'h8000000, 0);

    // Asynchronous reset while results and flags are held in DONE.
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_result", result, 32'd0);
    checkOutput("async_reset_flags", {29'b0, finish, overflow, underflow}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset in the middle of a ten-shift normalization.
    @(negedge clk);
    start   = 1'b1;
    sign_in = 1'b0;
    exp_in  = 10'd140;
    mant_in = 28'h0010000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_norm_reset", {result[30:0], finish}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    rises = 0;
    for (int c = 0; c < 35; c++) begin
      @(posedge clk);
      #1;
      if (finish) rises++;
    end
    checkOutput("idle_after_reset", 32'(rises), 32'd0);

    applyStimulus("after_reset", 1'b0, 10'd140, 28'h0010000, 0);
    applyStimulus("start_ignored", 1'b1, 10'd140, 28'h0010000, 3);

    for (int n = 0; n < 150; n++) begin
      w = $urandom_range(0, 28);
      if (w == 0) begin
        m = '0;
      end else begin
        m = 28'($urandom) & 28'((64'd1 << w) - 1);
        m[w-1] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) e = 10'($urandom);
      else e = 10'($urandom_range(0, 280));
      applyStimulus("random", 1'($urandom), e, m, 0);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
